// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: datapath width, funct3 encodings and the
// multiply/divide sequencer states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of the final product, quotient or remainder.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] value_c
);

  assign value_c = neg ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sign restored in a single fix-up cycle.
module mul_div_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_pkg::XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int unsigned AW = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_S = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q;
  funct3_e           f3_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [AW-1:0]     acc_q;
  logic [XLEN-1:0]   b_q;

  // Request decode on the incoming operands
  funct3_e         f3_in_c;
  logic            a_neg_c, b_neg_c, neg_in_c;
  logic            is_div_c, is_rem_c, div_zero_c, ovf_c, special_c, accept_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c, spec_val_c;

  assign f3_in_c  = funct3_e'(funct3);
  assign a_neg_c  = op_a[XLEN-1] & (f3_in_c inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
  assign b_neg_c  = op_b[XLEN-1] & (f3_in_c inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
  assign is_div_c = funct3[2];
  assign is_rem_c = funct3[2] & funct3[1];

  always_comb begin
    neg_in_c = 1'b0;
    case (f3_in_c)
      F3_MUL, F3_MULH, F3_DIV: neg_in_c = a_neg_c ^ b_neg_c;
      F3_MULHSU, F3_REM:       neg_in_c = a_neg_c;
      default:                 neg_in_c = 1'b0;
    endcase
  end

  assign div_zero_c = is_div_c && (op_b == '0);
  assign ovf_c      = (f3_in_c inside {F3_DIV, F3_REM}) && (op_a == MIN_S) && (op_b == '1);
  assign special_c  = div_zero_c | ovf_c;
  // Both halves carry the answer so the normal quotient/remainder select applies
  assign spec_val_c = div_zero_c ? (is_rem_c ? op_a : '1) : (is_rem_c ? '0 : MIN_S);
  assign accept_c   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  mdu_sign_fix #(.W(XLEN)) u_abs_a (.value(op_a), .neg(a_neg_c), .value_c(abs_a_c));
  mdu_sign_fix #(.W(XLEN)) u_abs_b (.value(op_b), .neg(b_neg_c), .value_c(abs_b_c));

  // One radix-2 step: multiply shifts right, divide shifts left
  logic [XLEN:0]   mul_sum_c, div_part_c;
  logic [XLEN+1:0] div_diff_c;
  logic [AW-1:0]   acc_step_c;

  assign mul_sum_c  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign div_part_c = acc_q[AW-1:XLEN-1];
  assign div_diff_c = {1'b0, div_part_c} - {2'b00, b_q};

  always_comb begin
    acc_step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    if (f3_q[2]) begin
      if (!div_diff_c[XLEN+1]) acc_step_c = {div_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                     acc_step_c = {div_part_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Fix-up: divide negates only the selected half, multiply the full product
  logic [AW-1:0]   fix_in_c, fix_out_c;
  logic [XLEN-1:0] res_c;

  assign fix_in_c = f3_q[2] ? {XLEN'(0), (f3_q[1] ? acc_q[AW-1:XLEN] : acc_q[XLEN-1:0])} : acc_q;

  mdu_sign_fix #(.W(AW)) u_fix (.value(fix_in_c), .neg(neg_q), .value_c(fix_out_c));

  assign res_c = (f3_q[2] || (f3_q == F3_MUL)) ? fix_out_c[XLEN-1:0] : fix_out_c[AW-1:XLEN];

  // Sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_n = accept_c ? (special_c ? S_FIX : S_CALC) : S_IDLE;
      S_CALC:         if (cnt_q == CNT_W'(XLEN - 1)) state_n = S_FIX;
      S_FIX:          state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      f3_q   <= F3_MUL;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      acc_q  <= '0;
      b_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rd_out <= '0;
      result <= '0;
    end else begin
      busy <= (state_n == S_CALC) || (state_n == S_FIX);
      done <= (state_n == S_DONE);
      if (accept_c) begin
        cnt_q <= '0;
        f3_q  <= f3_in_c;
        rd_q  <= rd_in;
        neg_q <= special_c ? 1'b0 : neg_in_c;
        acc_q <= special_c ? {spec_val_c, spec_val_c} : {XLEN'(0), abs_a_c};
        b_q   <= abs_b_c;
      end else if (state_q == S_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_step_c;
      end
      if (state_q == S_FIX) begin
        result <= res_c;
        rd_out <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: result values, latency,
// single done pulse, ignored/back-to-back starts and mid-operation reset.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .rd_out(rd_out), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
  endtask

  // Counts rising edges from the accepting edge until done; -1 on timeout.
  // poke>0 pulses a conflicting start after that many edges.
  task automatic wait_done(input int poke, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start = 1'b0; op_a = $urandom; op_b = $urandom;
        funct3 = 3'($urandom); rd_in = 5'($urandom);
      end
      if (poke > 0 && i == poke) begin
        start = 1'b1; funct3 = 3'b000; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd31;
      end else if (poke > 0 && i == poke + 1) begin
        start = 1'b0;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    launch(f3, a, b, rd);
    wait_done(0, lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result"}, result, exp);
    chk({tag, " rd_out"}, 32'(rd_out), 32'(rd));
    @(posedge clk); #1;
    chk({tag, " done single"}, 32'(done), 32'd0);
    chk({tag, " busy after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;

    // Reset state
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", 32'(rd_out), 32'd0);
    @(negedge clk); reset = 1'b1;

    // Multiply family
    run_op("MUL 7*-3",       3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34);
    run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34);
    run_op("MULHSU min*2^31",3'b010, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'hC000_0000, 34);
    run_op("MULHU 2^31*2^31",3'b011, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 34);
    run_op("MULHU max*max",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE, 34);
    run_op("MUL -1*-1",      3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001, 34);
    run_op("MULH -1*-1",     3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 34);
    run_op("MULHSU -1*max",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 34);

    // Divide family
    run_op("DIV -7/2",       3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFD, 34);
    run_op("REM -7/2",       3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 34);
    run_op("DIVU 100/7",     3'b101, 32'd100, 32'd7, 5'd11, 32'd14, 34);
    run_op("REMU 100/7",     3'b111, 32'd100, 32'd7, 5'd12, 32'd2, 34);
    run_op("DIV 7/-2",       3'b100, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 34);
    run_op("REM 7/-2",       3'b110, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'h0000_0001, 34);
    run_op("DIVU max/1",     3'b101, 32'hFFFF_FFFF, 32'd1, 5'd15, 32'hFFFF_FFFF, 34);

    // Special cases bypass the iteration
    run_op("DIVU 5/0",       3'b101, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF, 2);
    run_op("REM 5/0",        3'b110, 32'd5, 32'd0, 5'd17, 32'd5, 2);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 2);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 2);

    // Start during CALC is ignored
    @(negedge clk);
    launch(3'b000, 32'd6, 32'd9, 5'd20);
    @(posedge clk); #1;
    chk("hold result in calc", result, 32'h0000_0000);
    chk("busy in calc", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(5, lat);
    chk("ignored start latency", 32'(lat + 1), 32'd34);
    chk("ignored start result", result, 32'd54);
    chk("ignored start rd_out", 32'(rd_out), 32'd20);
    @(posedge clk); #1;
    chk("ignored start single done", 32'(done), 32'd0);
    chk("ignored start idle", 32'(busy), 32'd0);

    // Back-to-back: accept a new op in the DONE cycle
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd7, 5'd21);
    wait_done(0, lat);
    chk("b2b first result", result, 32'd14);
    chk("b2b first rd_out", 32'(rd_out), 32'd21);
    launch(3'b111, 32'd100, 32'd7, 5'd22);
    wait_done(0, lat);
    chk("b2b second latency", 32'(lat), 32'd34);
    chk("b2b second result", result, 32'd2);
    chk("b2b second rd_out", 32'(rd_out), 32'd22);

    // Reset mid-DIV aborts without a done pulse
    @(negedge clk);
    launch(3'b100, 32'd1000, 32'd3, 5'd23);
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort rd_out", 32'(rd_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort no done", 32'(done), 32'd0);
    end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      chk("post reset quiet", 32'(done), 32'd0);
    end
    run_op("MUL after reset", 3'b000, 32'd12345, 32'd678, 5'd24, 32'd8369910, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
